// File: rtl/reg_write_arbiter.sv
// Shared-register write arbiter. Requesters compete for ownership of one
// register using round-robin selection. The owner may extend its burst with
// lock, up to MAX_BURST writes. Every release leaves one idle bubble cycle.
module reg_write_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4,
  localparam int OW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       lock,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       q,
  output logic                   q_valid,
  output logic [OW-1:0]          owner,
  output logic                   busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [OW-1:0]      ptr_q, ptr_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               dataValid_q, dataValid_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [OW-1:0]      owner_q, owner_d;

  logic [OW-1:0]      winner;
  logic               winnerFound;
  int                 scanIdx;

  // Round-robin scan: first set request starting at ptr, wrapping modulo N_REQ.
  always_comb begin
    winner      = '0;
    winnerFound = 1'b0;
    scanIdx     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      scanIdx = int'(ptr_q) + k;
      if (scanIdx >= N_REQ) begin
        scanIdx = scanIdx - N_REQ;
      end
      if (!winnerFound && req[scanIdx]) begin
        winnerFound = 1'b1;
        winner      = OW'(scanIdx);
      end
    end
  end

  // Next-state logic: grant from IDLE, extend or release while OWNED.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    dataValid_d = 1'b0;
    gnt_d       = gnt_q;
    owner_d     = owner_q;

    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (winnerFound) begin
          data_d      = wdata[int'(winner)*WIDTH +: WIDTH];
          owner_d     = winner;
          gnt_d       = N_REQ'(1) << winner;
          cnt_d       = 4'd1;
          dataValid_d = 1'b1;
          state_d     = OWNED;
        end
      end
      OWNED: begin
        if (req[owner_q] && lock[owner_q] && (cnt_q < 4'(MAX_BURST))) begin
          data_d      = wdata[int'(owner_q)*WIDTH +: WIDTH];
          cnt_d       = cnt_q + 4'd1;
          dataValid_d = 1'b1;
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
          if (int'(owner_q) == N_REQ - 1) begin
            ptr_d = '0;
          end else begin
            ptr_d = OW'(owner_q + 1'b1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State registers with synchronous active-low reset overriding all inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      dataValid_q <= 1'b0;
      gnt_q       <= '0;
      owner_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      dataValid_q <= dataValid_d;
      gnt_q       <= gnt_d;
      owner_q     <= owner_d;
    end
  end

  assign gnt     = gnt_q;
  assign q       = data_q;
  assign q_valid = dataValid_q;
  assign owner   = owner_q;
  assign busy    = (state_q == OWNED);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter (N_REQ=4, WIDTH=8, MAX_BURST=4).
// Stimulus pushes each expected write tagged with the cycle it must appear in;
// a monitor on the falling edge pops and compares whenever q_valid is seen.
module tb_reg_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic        q_valid;
  logic [1:0]  owner;
  logic        busy;

  typedef struct {
    int         cyc;
    logic [1:0] owner;
    logic [7:0] data;
  } expT;

  expT sbQ[$];
  int  cyc;
  int  testsRun;
  int  testsFailed;

  reg_write_arbiter #(
    .N_REQ    (4),
    .WIDTH    (8),
    .MAX_BURST(4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .lock   (lock),
    .wdata  (wdata),
    .gnt    (gnt),
    .q      (q),
    .q_valid(q_valid),
    .owner  (owner),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used to tag when each expected write must become visible.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every write seen must match the oldest expectation for this cycle.
  always @(negedge clk) begin
    while (sbQ.size() > 0 && sbQ[0].cyc < cyc) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL missingWrite cyc=%0d: got q_valid=0, expected write q=%h owner=%0d",
               sbQ[0].cyc, sbQ[0].data, sbQ[0].owner);
      void'(sbQ.pop_front());
    end
    if (q_valid === 1'b1) begin
      testsRun++;
      if (sbQ.size() == 0 || sbQ[0].cyc != cyc) begin
        testsFailed++;
        $display("[TB] FAIL unexpectedWrite cyc=%0d: got q=%h owner=%0d, expected no write",
                 cyc, q, owner);
      end else begin
        if (q !== sbQ[0].data || owner !== sbQ[0].owner ||
            gnt !== (4'b0001 << sbQ[0].owner) || busy !== 1'b1) begin
          testsFailed++;
          $display("[TB] FAIL write cyc=%0d: got q=%h owner=%0d gnt=%b busy=%b, expected q=%h owner=%0d gnt=%b busy=1",
                   cyc, q, owner, gnt, busy, sbQ[0].data, sbQ[0].owner,
                   4'b0001 << sbQ[0].owner);
        end
        void'(sbQ.pop_front());
      end
    end else if (q_valid !== 1'b0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL qValidX cyc=%0d: got q_valid=%b, expected 0 or 1", cyc, q_valid);
    end
  end

  // Drive one cycle of inputs and record the write it should cause.
  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] l,
                               input logic [31:0] wd, input bit expW,
                               input logic [1:0] expOwner, input logic [7:0] expData);
    expT e;
    req   = r;
    lock  = l;
    wdata = wd;
    if (expW) begin
      e.cyc   = cyc + 1;
      e.owner = expOwner;
      e.data  = expData;
      sbQ.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Direct comparison of the full output state at a quiet point.
  task automatic checkOutput(input string name, input logic [7:0] expQ,
                             input logic [3:0] expGnt, input logic expBusy,
                             input logic expValid, input logic [1:0] expOwner);
    testsRun++;
    if (q !== expQ || gnt !== expGnt || busy !== expBusy ||
        q_valid !== expValid || owner !== expOwner) begin
      testsFailed++;
      $display("[TB] FAIL %s: got q=%h gnt=%b busy=%b q_valid=%b owner=%0d, expected q=%h gnt=%b busy=%b q_valid=%b owner=%0d",
               name, q, gnt, busy, q_valid, owner,
               expQ, expGnt, expBusy, expValid, expOwner);
    end
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus with hand-computed expected writes.
  initial begin
    cyc         = 0;
    testsRun    = 0;
    testsFailed = 0;
    rst_n = 1'b0;
    req   = '0;
    lock  = '0;
    wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetState", 8'h00, 4'b0000, 1'b0, 1'b0, 2'd0);
    rst_n = 1'b1;

    // Round robin with all requesting: 0,1,2,3,0 with bubbles.
    applyStimulus(4'b1111, 4'b0000, 32'h13121110, 1, 2'd0, 8'h10);
    applyStimulus(4'b1111, 4'b0000, 32'h13121110, 0, 2'd0, 8'h00);
    applyStimulus(4'b1111, 4'b0000, 32'h13121110, 1, 2'd1, 8'h11);
    applyStimulus(4'b1111, 4'b0000, 32'h13121110, 0, 2'd0, 8'h00);
    applyStimulus(4'b1111, 4'b0000, 32'h13121110, 1, 2'd2, 8'h12);
    applyStimulus(4'b1111, 4'b0000, 32'h13121110, 0, 2'd0, 8'h00);
    applyStimulus(4'b1111, 4'b0000, 32'h13121110, 1, 2'd3, 8'h13);
    applyStimulus(4'b1111, 4'b0000, 32'h13121110, 0, 2'd0, 8'h00);
    applyStimulus(4'b1111, 4'b0000, 32'h13121110, 1, 2'd0, 8'h10);
    applyStimulus(4'b1111, 4'b0000, 32'h13121110, 0, 2'd0, 8'h00);
    applyStimulus(4'b0000, 4'b0000, 32'h00000000, 0, 2'd0, 8'h00);
    checkOutput("idleHold", 8'h10, 4'b0000, 1'b0, 1'b0, 2'd0);

    // Lock without request in IDLE: nothing happens.
    applyStimulus(4'b0000, 4'b1111, 32'hEEEEEEEE, 0, 2'd0, 8'h00);
    checkOutput("lockNoReq", 8'h10, 4'b0000, 1'b0, 1'b0, 2'd0);

    // Burst limit: 4 writes, forced release, bubble, regrant writes A4.
    applyStimulus(4'b0100, 4'b0100, 32'h00A00000, 1, 2'd2, 8'hA0);
    applyStimulus(4'b0100, 4'b0100, 32'h00A10000, 1, 2'd2, 8'hA1);
    applyStimulus(4'b0100, 4'b0100, 32'h00A20000, 1, 2'd2, 8'hA2);
    applyStimulus(4'b0100, 4'b0100, 32'h00A30000, 1, 2'd2, 8'hA3);
    applyStimulus(4'b0100, 4'b0100, 32'h00A40000, 0, 2'd0, 8'h00);
    checkOutput("forcedRelease", 8'hA3, 4'b0000, 1'b0, 1'b0, 2'd2);
    applyStimulus(4'b0100, 4'b0100, 32'h00A40000, 1, 2'd2, 8'hA4);
    applyStimulus(4'b0000, 4'b0000, 32'h00000000, 0, 2'd0, 8'h00);
    applyStimulus(4'b0000, 4'b0000, 32'h00000000, 0, 2'd0, 8'h00);

    // Lock for two cycles then drop: writes 1,1 then release.
    applyStimulus(4'b0010, 4'b0010, 32'h0000B000, 1, 2'd1, 8'hB0);
    applyStimulus(4'b0010, 4'b0010, 32'h0000B100, 1, 2'd1, 8'hB1);
    applyStimulus(4'b0010, 4'b0000, 32'h0000B200, 0, 2'd0, 8'h00);
    applyStimulus(4'b0000, 4'b0000, 32'h00000000, 0, 2'd0, 8'h00);

    // Owner 3 holds while requester 0 waits with 55; ptr wraps to 0 afterwards.
    applyStimulus(4'b1001, 4'b1000, 32'hC0000055, 1, 2'd3, 8'hC0);
    applyStimulus(4'b1001, 4'b1000, 32'hC1000055, 1, 2'd3, 8'hC1);
    applyStimulus(4'b1001, 4'b1000, 32'hC2000055, 1, 2'd3, 8'hC2);
    applyStimulus(4'b1001, 4'b0000, 32'hC3000055, 0, 2'd0, 8'h00);
    applyStimulus(4'b1001, 4'b0000, 32'hC4000055, 1, 2'd0, 8'h55);
    applyStimulus(4'b0000, 4'b0000, 32'h00000000, 0, 2'd0, 8'h00);

    // Reset in the second cycle of a burst aborts with no write.
    applyStimulus(4'b0010, 4'b0010, 32'h00007700, 1, 2'd1, 8'h77);
    rst_n = 1'b0;
    req   = 4'b0010;
    lock  = 4'b0010;
    wdata = 32'h00007800;
    @(posedge clk);
    #1;
    checkOutput("resetMidBurst", 8'h00, 4'b0000, 1'b0, 1'b0, 2'd0);
    rst_n = 1'b1;
    // Arbitration restarts at ptr=0, so requester 0 beats requester 3.
    applyStimulus(4'b1001, 4'b0000, 32'h93000090, 1, 2'd0, 8'h90);
    applyStimulus(4'b0000, 4'b0000, 32'h00000000, 0, 2'd0, 8'h00);

    // Lone requester 1 re-wins every second cycle.
    applyStimulus(4'b0010, 4'b0000, 32'h0000E100, 1, 2'd1, 8'hE1);
    applyStimulus(4'b0010, 4'b0000, 32'h0000E200, 0, 2'd0, 8'h00);
    applyStimulus(4'b0010, 4'b0000, 32'h0000E300, 1, 2'd1, 8'hE3);
    applyStimulus(4'b0010, 4'b0000, 32'h0000E400, 0, 2'd0, 8'h00);
    applyStimulus(4'b0000, 4'b0000, 32'h00000000, 0, 2'd0, 8'h00);
    checkOutput("finalIdle", 8'hE3, 4'b0000, 1'b0, 1'b0, 2'd1);

    repeat (3) @(posedge clk);
    #1;
    testsRun++;
    if (sbQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL scoreboardDrain: got %0d pending writes, expected 0", sbQ.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 The block SHALL have parameter WIDTH, default 8, shared register width.
REQ-003 The block SHALL have parameter MAX_BURST, default 4, max consecutive writes per ownership (1..15).
REQ-004 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 The block SHALL have port req  input  N_REQ  per-requester write request.
REQ-007 The block SHALL have port lock  input  N_REQ  per-requester burst-extend request.
REQ-008 The block SHALL have port wdata  input  N_REQ*WIDTH  write data; requester i at bits [i*WIDTH +: WIDTH].
REQ-009 The block SHALL have port gnt  output  N_REQ  registered one-hot ownership indication.
REQ-010 The block SHALL have port q  output  WIDTH  shared register contents.
REQ-011 The block SHALL have port q_valid  output  1  high for the one cycle after each write to q.
REQ-012 The block SHALL have port owner  output  max(1,clog2(N_REQ))  index of the current or last owner.
REQ-013 The block SHALL have port busy  output  1  high while in state OWNED.

Function
REQ-014 The block SHALL implement the two states IDLE and OWNED, plus a rotation pointer ptr and a burst counter cnt.
REQ-015 In IDLE with req==0, the block SHALL hold all state; gnt=0, q_valid=0 next cycle.
REQ-016 In IDLE with req!=0, the block SHALL select winner w as the first set req bit scanning ptr, ptr+1, ... modulo N_REQ.
REQ-017 On that edge: q<=wdata[w], owner<=w, gnt<=onehot(w), cnt<=1, q_valid<=1, state<=OWNED (grant-edge write, zero-cycle write latency, gnt visible one cycle later).
REQ-018 In OWNED, if req[owner]&lock[owner]&(cnt<MAX_BURST): q<=wdata[owner], cnt<=cnt+1, q_valid<=1, stay OWNED.
REQ-019 In OWNED otherwise: release; state<=IDLE, gnt<=0, ptr<=(owner+1) mod N_REQ, q_valid<=0, q held.
REQ-020 After every release, the block SHALL leave one idle bubble cycle; no write occurs on the release edge.
REQ-021 Requests and data from non-owners SHALL be ignored in OWNED; q is never written from a non-owner.
REQ-022 lock without req SHALL have no effect; lock in IDLE SHALL not affect arbitration.
REQ-023 Reaching cnt==MAX_BURST with lock held SHALL force release (fairness); with MAX_BURST=1 every ownership is one write.
REQ-024 A released owner SHALL regain ownership only if no other requester is set at the next IDLE arbitration (rotation starts at owner+1).
REQ-025 ptr SHALL wrap from N_REQ-1 to 0.
REQ-026 q_valid SHALL be low in any cycle following an edge with no write.
REQ-027 busy SHALL equal (state==OWNED); gnt SHALL be nonzero iff busy.

Reset
REQ-028 With rst_n=0 at an edge, the block SHALL set state=IDLE, q=0, q_valid=0, gnt=0, owner=0, ptr=0, cnt=0, overriding all other inputs.
REQ-029 Reset asserted mid-burst SHALL abort ownership with no write on that edge; first arbitration after rst_n=1 starts at ptr=0.

Verification
REQ-030 Reset, then req=4'b1111 with wdata[i]=8'h10+i, lock=0 -> grant order 0,1,2,3,0 with one IDLE bubble between; q sequence 10,11,12,13,10.
REQ-031 req[2]=1, lock[2]=1 held, wdata[2] stepping A0,A1,A2,A3,A4 -> exactly 4 writes (q ends 8'hA3), forced release, then A4 written after bubble.
REQ-032 req[1]=1 lock[1]=1 for 2 cycles, then lock[1]=0 -> 3 writes total? no: writes on grant edge and one extend edge, release on third edge; q_valid pattern 1,1,0.
REQ-033 Owner 3 holding lock while req[0]=1, wdata[0]=8'h55 -> q never equals 8'h55 until owner 3 releases; then ptr wraps to 0 and 0 wins.
REQ-034 rst_n=0 during cycle 2 of a burst with q=8'h77 -> next cycle q=8'h00, gnt=0, busy=0, q_valid=0.
REQ-035 Only req[1] asserted continuously, lock=0 -> owner 1 re-wins every second cycle (grant, release, grant...), q_valid toggles 1,0,1,0.
